// File: rtl/frogger_game_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : frogger_game_fsm_pkg
// Brief   : Shared widths, state codes and helpers for the Frogger sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package frogger_game_fsm_pkg;

    localparam int LIVES_W    = 2;
    localparam int LEVEL_W    = 7;
    localparam int TILE_ROW_W = 6;
    localparam int TILE_COL_W = 5;
    localparam int STATE_W    = 3;
    localparam int FRAME_W    = 8;

    localparam logic [STATE_W-1:0] c_ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] c_ST_PLAY      = 3'd1;
    localparam logic [STATE_W-1:0] c_ST_HIT       = 3'd2;
    localparam logic [STATE_W-1:0] c_ST_LEVEL_UP  = 3'd3;
    localparam logic [STATE_W-1:0] c_ST_RESPAWN   = 3'd4;
    localparam logic [STATE_W-1:0] c_ST_GAME_OVER = 3'd5;

    // Thermometer code for the lives LEDs: bit n lit when lives > n.
    function automatic logic [2:0] lives_to_led(input logic [LIVES_W-1:0] lives);
        return {lives > 2'd2, lives > 2'd1, lives > 2'd0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/frogger_game_fsm_frame_timer.sv
`default_nettype none
// ============================================================================
// Module  : frogger_game_fsm_frame_timer
// Brief   : Saturating frame-tick counter with clear, compare and tap output.
// Revision: 1.0 - initial release
// ============================================================================
module frogger_game_fsm_frame_timer #(
    parameter int WIDTH = 8,
    parameter int TAP   = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] cmp_i,
    output logic             match_o,
    output logic             tap_next_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (tick_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign match_o    = (count_q == cmp_i);
    // The tap is taken from the next value so a registered consumer lines up with the count.
    assign tap_next_o = count_d[TAP];

endmodule
`default_nettype wire

// File: rtl/frogger_game_fsm.sv
`default_nettype none
// ============================================================================
// Module  : frogger_game_fsm
// Brief   : Frogger game sequencer: lives, level, phase and gameplay enables.
// Revision: 1.0 - initial release
// ============================================================================
module frogger_game_fsm
    import frogger_game_fsm_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int MAX_LEVEL    = 99,
    parameter int DEATH_FRAMES = 60,
    parameter int WIN_FRAMES   = 30,
    parameter int GOAL_ROW     = 0,
    parameter int FLASH_BIT    = 3
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic                  i_Frame_Tick,
    input  logic                  i_Game_Start,
    input  logic                  i_Collided,
    input  logic [TILE_ROW_W-1:0] i_Frog_Y,
    output logic [STATE_W-1:0]    o_State,
    output logic [LIVES_W-1:0]    o_Lives,
    output logic [LEVEL_W-1:0]    o_Level,
    output logic [2:0]            o_Lives_LED,
    output logic                  o_Frog_Reset,
    output logic                  o_Input_Enable,
    output logic                  o_Cars_Enable,
    output logic                  o_Flash,
    output logic                  o_Game_Over
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               grace_q, grace_d;
    logic               start_q;
    logic               frog_reset_q, frog_reset_d;
    logic               enable_q, enable_d;
    logic               flash_q, flash_d;
    logic               game_over_q, game_over_d;
    logic [2:0]         led_q, led_d;

    logic               w_start_rise;
    logic               w_hit;
    logic               w_goal;
    logic               w_state_change;
    logic               w_timer_match;
    logic               w_flash_next;
    logic [FRAME_W-1:0] w_timer_cmp;

    assign w_start_rise   = i_Game_Start & ~start_q;
    assign w_hit          = i_Collided & grace_q;
    assign w_goal         = (i_Frog_Y == TILE_ROW_W'(GOAL_ROW));
    assign w_state_change = (state_d != state_q);
    assign w_timer_cmp    = (state_q == c_ST_HIT) ? FRAME_W'(DEATH_FRAMES) : FRAME_W'(WIN_FRAMES);

    frogger_game_fsm_frame_timer #(
        .WIDTH (FRAME_W),
        .TAP   (FLASH_BIT)
    ) u_frame_timer (
        .clk_i      (i_Clk),
        .rst_i      (i_Reset),
        .tick_i     (i_Frame_Tick),
        .clear_i    (w_state_change),
        .cmp_i      (w_timer_cmp),
        .match_o    (w_timer_match),
        .tap_next_o (w_flash_next)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q      <= c_ST_IDLE;
            lives_q      <= LIVES_W'(LIVES_INIT);
            level_q      <= '0;
            grace_q      <= 1'b0;
            start_q      <= 1'b1;
            frog_reset_q <= 1'b0;
            enable_q     <= 1'b0;
            flash_q      <= 1'b0;
            game_over_q  <= 1'b0;
            led_q        <= lives_to_led(LIVES_W'(LIVES_INIT));
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            grace_q      <= grace_d;
            start_q      <= i_Game_Start;
            frog_reset_q <= frog_reset_d;
            enable_q     <= enable_d;
            flash_q      <= flash_d;
            game_over_q  <= game_over_d;
            led_q        <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        level_d = level_q;
        case (state_q)
            c_ST_IDLE, c_ST_GAME_OVER: begin
                if (w_start_rise) begin
                    lives_d = LIVES_W'(LIVES_INIT);
                    level_d = '0;
                    state_d = c_ST_PLAY;
                end
            end
            c_ST_PLAY: begin
                // A collision outranks reaching the goal in the same cycle.
                if (w_hit) begin
                    lives_d = lives_q - LIVES_W'(1);
                    state_d = c_ST_HIT;
                end else if (w_goal) begin
                    level_d = (level_q >= LEVEL_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL)
                                                               : level_q + LEVEL_W'(1);
                    state_d = c_ST_LEVEL_UP;
                end
            end
            c_ST_HIT: begin
                if (w_timer_match) begin
                    state_d = (lives_q == '0) ? c_ST_GAME_OVER : c_ST_RESPAWN;
                end
            end
            c_ST_LEVEL_UP: begin
                if (w_timer_match) begin
                    state_d = c_ST_RESPAWN;
                end
            end
            c_ST_RESPAWN: begin
                state_d = c_ST_PLAY;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        frog_reset_d = (state_d == c_ST_PLAY) && (state_q != c_ST_PLAY);
        enable_d     = (state_d == c_ST_PLAY);
        flash_d      = (state_d == c_ST_HIT) && w_flash_next;
        game_over_d  = (state_d == c_ST_GAME_OVER);
        led_d        = lives_to_led(lives_d);
        // Collisions stay masked after each PLAY entry until a frame tick arrives.
        grace_d      = grace_q;
        if (frog_reset_d) begin
            grace_d = 1'b0;
        end else if ((state_q == c_ST_PLAY) && i_Frame_Tick) begin
            grace_d = 1'b1;
        end
    end

    assign o_State        = state_q;
    assign o_Lives        = lives_q;
    assign o_Level        = level_q;
    assign o_Lives_LED    = led_q;
    assign o_Frog_Reset   = frog_reset_q;
    assign o_Input_Enable = enable_q;
    assign o_Cars_Enable  = enable_q;
    assign o_Flash        = flash_q;
    assign o_Game_Over    = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_frogger_game_fsm.sv
`default_nettype none
// ============================================================================
// Module  : tb_frogger_game_fsm
// Brief   : Self-checking bench for frogger_game_fsm (vectors, sequences, random).
// Revision: 1.0 - initial release
// ============================================================================
module tb_frogger_game_fsm;

    localparam int P_IDLE = 0;
    localparam int P_PLAY = 1;
    localparam int P_HIT  = 2;
    localparam int P_LVL  = 3;
    localparam int P_RESP = 4;
    localparam int P_OVER = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       coll = 1'b0;
    logic [5:0] frog_y = 6'd10;
    logic [2:0] o_state;
    logic [1:0] o_lives;
    logic [6:0] o_level;
    logic [2:0] o_led;
    logic       o_fr, o_ien, o_cen, o_flash, o_go;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the game rules, advanced once per clock.
    int m_phase, m_lives, m_level, m_cnt;
    bit m_grace, m_start_prev, m_fr;

    frogger_game_fsm dut (
        .i_Clk          (clk),
        .i_Reset        (rst),
        .i_Frame_Tick   (tick),
        .i_Game_Start   (start),
        .i_Collided     (coll),
        .i_Frog_Y       (frog_y),
        .o_State        (o_state),
        .o_Lives        (o_lives),
        .o_Level        (o_level),
        .o_Lives_LED    (o_led),
        .o_Frog_Reset   (o_fr),
        .o_Input_Enable (o_ien),
        .o_Cars_Enable  (o_cen),
        .o_Flash        (o_flash),
        .o_Game_Over    (o_go)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit s, input bit c, input bit t, input int fy, input bit r);
        int  nxt;
        bit  rise;
        if (r) begin
            m_phase = P_IDLE; m_lives = 3; m_level = 0; m_cnt = 0;
            m_grace = 0; m_start_prev = 1; m_fr = 0;
        end else begin
            rise = s && !m_start_prev;
            m_start_prev = s;
            nxt = m_phase;
            case (m_phase)
                P_IDLE, P_OVER: if (rise) begin m_lives = 3; m_level = 0; nxt = P_PLAY; end
                P_PLAY: begin
                    if (c && m_grace) begin
                        m_lives = m_lives - 1; nxt = P_HIT;
                    end else if (fy == 0) begin
                        m_level = (m_level + 1 > 99) ? 99 : m_level + 1; nxt = P_LVL;
                    end
                end
                P_HIT:  if (m_cnt == 60) nxt = (m_lives == 0) ? P_OVER : P_RESP;
                P_LVL:  if (m_cnt == 30) nxt = P_RESP;
                P_RESP: nxt = P_PLAY;
                default: nxt = P_IDLE;
            endcase
            m_fr = (nxt == P_PLAY) && (m_phase != P_PLAY);
            if (m_fr) m_grace = 0;
            else if (m_phase == P_PLAY && t) m_grace = 1;
            if (nxt != m_phase) m_cnt = 0;
            else if (t && m_cnt < 255) m_cnt = m_cnt + 1;
            m_phase = nxt;
        end
    endtask

    task automatic compare_all();
        check("model_state", int'(o_state), m_phase);
        check("model_lives", int'(o_lives), m_lives);
        check("model_level", int'(o_level), m_level);
        check("model_led", int'(o_led), (1 << m_lives) - 1);
        check("model_frog_reset", int'(o_fr), int'(m_fr));
        check("model_input_en", int'(o_ien), int'(m_phase == P_PLAY));
        check("model_cars_en", int'(o_cen), int'(m_phase == P_PLAY));
        check("model_flash", int'(o_flash), int'(m_phase == P_HIT && ((m_cnt >> 3) & 1) == 1));
        check("model_game_over", int'(o_go), int'(m_phase == P_OVER));
    endtask

    task automatic step(input bit s, input bit c, input bit t, input int fy, input bit r);
        start  = s;
        coll   = c;
        tick   = t;
        frog_y = 6'(fy);
        rst    = r;
        @(posedge clk);
        #1;
        model_update(s, c, t, fy, r);
        compare_all();
    endtask

    typedef struct {
        bit start; bit coll; bit tick; int fy;
        int st; int lives; int fr; int en;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{start:0, coll:0, tick:0, fy:10, st:P_IDLE, lives:3, fr:0, en:0};
        tbl[1] = '{start:1, coll:0, tick:0, fy:10, st:P_PLAY, lives:3, fr:1, en:1};
        tbl[2] = '{start:1, coll:1, tick:0, fy:10, st:P_PLAY, lives:3, fr:0, en:1};
        tbl[3] = '{start:0, coll:1, tick:1, fy:10, st:P_PLAY, lives:3, fr:0, en:1};
        tbl[4] = '{start:0, coll:1, tick:0, fy:10, st:P_HIT,  lives:2, fr:0, en:0};
        tbl[5] = '{start:0, coll:0, tick:0, fy:10, st:P_HIT,  lives:2, fr:0, en:0};

        // Reset state
        step(0, 0, 0, 10, 1);
        step(0, 0, 0, 10, 1);
        check("rst_state", int'(o_state), P_IDLE);
        check("rst_lives", int'(o_lives), 3);
        check("rst_led", int'(o_led), 7);
        check("rst_outs", int'({o_fr, o_ien, o_cen, o_flash, o_go}), 0);

        // Start, grace window and first collision
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].start, tbl[i].coll, tbl[i].tick, tbl[i].fy, 0);
            check("tbl_state", int'(o_state), tbl[i].st);
            check("tbl_lives", int'(o_lives), tbl[i].lives);
            check("tbl_frog_reset", int'(o_fr), tbl[i].fr);
            check("tbl_enable", int'(o_ien), tbl[i].en);
        end
        check("led_two_lives", int'(o_led), 3);
        check("level_start", int'(o_level), 0);

        // Death blink and HIT duration
        for (int k = 1; k <= 60; k++) begin
            step(0, 0, 1, 10, 0);
            check("hit_flash", int'(o_flash), (k >> 3) & 1);
            check("hit_hold", int'(o_state), P_HIT);
        end
        step(0, 0, 0, 10, 0);
        check("respawn_state", int'(o_state), P_RESP);
        check("respawn_no_fr", int'(o_fr), 0);
        step(0, 0, 0, 10, 0);
        check("respawn_to_play", int'(o_state), P_PLAY);
        check("respawn_fr", int'(o_fr), 1);

        // Collision and goal in the same cycle
        step(0, 0, 1, 10, 0);
        step(0, 1, 0, 0, 0);
        check("coll_goal_state", int'(o_state), P_HIT);
        check("coll_goal_level", int'(o_level), 0);
        check("coll_goal_lives", int'(o_lives), 1);
        check("led_one_life", int'(o_led), 1);

        // Collision held across RESPAWN: masked until a frame tick
        repeat (60) step(0, 0, 1, 10, 0);
        step(0, 1, 0, 10, 0);
        check("held_respawn", int'(o_state), P_RESP);
        step(0, 1, 0, 10, 0);
        step(0, 1, 0, 10, 0);
        check("grace_no_loss", int'(o_lives), 1);
        check("grace_play", int'(o_state), P_PLAY);
        step(0, 1, 1, 10, 0);
        check("grace_tick_cycle", int'(o_state), P_PLAY);
        step(0, 1, 0, 10, 0);
        check("grace_after_tick", int'(o_state), P_HIT);
        check("lives_zero", int'(o_lives), 0);
        check("led_zero", int'(o_led), 0);

        // Last life gone: GAME_OVER, then restart
        repeat (61) step(0, 0, 1, 10, 0);
        check("game_over_state", int'(o_state), P_OVER);
        check("game_over_flag", int'(o_go), 1);
        check("game_over_lives", int'(o_lives), 0);
        step(1, 0, 0, 10, 0);
        check("restart_state", int'(o_state), P_PLAY);
        check("restart_lives", int'(o_lives), 3);
        check("restart_fr", int'(o_fr), 1);

        // Level saturation
        for (int lv = 1; lv <= 100; lv++) begin
            step(1, 0, 0, 0, 0);
            check("level_inc", int'(o_level), (lv > 99) ? 99 : lv);
            repeat (31) step(1, 0, 1, 5, 0);
            step(1, 0, 0, 5, 0);
        end
        check("level_sat", int'(o_level), 99);

        // Reset in the middle of HIT
        step(0, 0, 1, 5, 0);
        step(0, 1, 0, 5, 0);
        check("pre_reset_hit", int'(o_state), P_HIT);
        repeat (5) step(0, 0, 1, 5, 0);
        step(0, 0, 0, 5, 1);
        check("midrst_state", int'(o_state), P_IDLE);
        check("midrst_lives", int'(o_lives), 3);
        check("midrst_level", int'(o_level), 0);
        check("midrst_led", int'(o_led), 7);
        check("midrst_outs", int'({o_fr, o_ien, o_cen, o_flash, o_go}), 0);

        // Start rising together with reset, then held through it
        step(0, 0, 0, 5, 0);
        step(1, 0, 0, 5, 1);
        check("rst_kills_fr", int'(o_fr), 0);
        step(1, 0, 0, 5, 0);
        check("held_start_idle", int'(o_state), P_IDLE);

        // Randomized play against the model
        for (int n = 0; n < 4000; n++) begin
            step($urandom_range(0, 15) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63)),
                 $urandom_range(0, 599) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
